// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// Optional feature macro: DMEM_RESP_ERR_EN (error reporting on dmem_err).
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_resp_state_t;

  // Byte, aligned halfword and full word are the only access shapes the LSU issues.
  function automatic logic dmem_mask_legal(input logic [3:0] mask);
    logic legal;
    case (mask)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: legal = 1'b1;
      default:                   legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Expands a 4-bit byte mask into a 32-bit bit mask.
  function automatic logic [31:0] dmem_mask_bits(input logic [3:0] mask);
    return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the load/store FU (master) and the data memory (slave).
// dmem_err exists only when DMEM_RESP_ERR_EN is defined.
interface dmem_responder_if;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
`ifdef DMEM_RESP_ERR_EN
  logic        dmem_err;

  modport master (
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp, dmem_err
  );
  modport slave (
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp, dmem_err
  );
`else
  modport master (
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );
  modport slave (
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
`endif
endinterface

// File: rtl/dmem_sram_array.sv
// DEPTH_WORDS x 32 storage: combinational read, synchronous byte-enabled write.
// Contents are deliberately not reset.
module dmem_sram_array #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] idx_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  assign rdata_o = mem_q[idx_i];

  // Update only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i && be_i[b]) begin
        mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: one outstanding request, fixed LATENCY cycles from accept to dmem_resp.
// Optional feature macro: DMEM_RESP_ERR_EN adds dmem_err for out-of-range addresses and
// malformed masks; without it addresses alias and any mask is served.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | no request in flight; accepts and latches a new request
//  WAIT  | latency down-counter running; all-zero masks abort
//  RESP  | completion cycle: dmem_resp pulses, write commits at its end
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  dmem_s
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_WAIT = 2'(WAIT);
  localparam logic [1:0] ST_RESP = 2'(RESP);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [3:0]    rmask_q, rmask_d;
  logic [3:0]    wmask_q, wmask_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q;

  logic          req_present;
  logic          resp;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  assign req_present = |{dmem_s.dmem_rmask, dmem_s.dmem_wmask};

`ifdef DMEM_RESP_ERR_EN
  logic err_d;
  logic req_bad;

  assign req_bad = (dmem_s.dmem_addr >= 32'(DEPTH_WORDS * 4))
                || ((dmem_s.dmem_rmask != 4'b0) && !dmem_mask_legal(dmem_s.dmem_rmask))
                || ((dmem_s.dmem_wmask != 4'b0) && !dmem_mask_legal(dmem_s.dmem_wmask));

  // Error flag is captured with the rest of the request and held until completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  // Classify the request only when it is accepted.
  always_comb begin
    err_d = err_q;
    if (state_q == ST_IDLE && req_present) begin
      err_d = req_bad;
    end
  end

  assign dmem_s.dmem_err = resp && err_q;
`else
  assign err_q = 1'b0;
`endif

  // Address bits outside the word index never influence the default build.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{dmem_s.dmem_addr[1:0], dmem_s.dmem_addr[31:2+AW]};

  // Next-state, latency counter and request latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rmask_d = rmask_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_present) begin
          idx_d   = dmem_s.dmem_addr[2 +: AW];
          rmask_d = dmem_s.dmem_rmask;
          wmask_d = dmem_s.dmem_wmask;
          wdata_d = dmem_s.dmem_wdata;
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!req_present) begin
          // Initiator flushed the request; nothing is written or answered.
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM, counter and latched request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      rmask_q <= 4'b0;
      wmask_q <= 4'b0;
      wdata_q <= 32'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rmask_q <= rmask_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
    end
  end

  // A request withdrawn in its RESP cycle is silently dropped, as is one caught by reset.
  assign resp   = (state_q == ST_RESP) && req_present && !rst;
  assign mem_we = resp && !err_q && (wmask_q != 4'b0);

  // Read uses the array's pre-write contents; the write lands on the closing edge.
  assign dmem_s.dmem_resp  = resp;
  assign dmem_s.dmem_rdata = (resp && !err_q) ? (mem_rdata & dmem_mask_bits(rmask_q)) : 32'b0;

  dmem_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .idx_i   (idx_q),
    .we_i    (mem_we),
    .be_i    (wmask_q),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance at LATENCY=2 and one at LATENCY=3 share the
// stimulus; sel routes the request masks to one of them. Expected read data comes from
// a word-level model and is queued as each request is driven.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] addr_d  = 32'b0;
  logic [3:0]  rm_d    = 4'b0;
  logic [3:0]  wm_d    = 4'b0;
  logic [31:0] wdata_d = 32'b0;
  logic        sel     = 1'b0;

  dmem_responder_if ifc2();
  dmem_responder_if ifc3();

  assign ifc2.dmem_addr  = addr_d;
  assign ifc2.dmem_wdata = wdata_d;
  assign ifc2.dmem_rmask = sel ? 4'b0 : rm_d;
  assign ifc2.dmem_wmask = sel ? 4'b0 : wm_d;
  assign ifc3.dmem_addr  = addr_d;
  assign ifc3.dmem_wdata = wdata_d;
  assign ifc3.dmem_rmask = sel ? rm_d : 4'b0;
  assign ifc3.dmem_wmask = sel ? wm_d : 4'b0;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut2 (.clk(clk), .rst(rst), .dmem_s(ifc2));
  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut3 (.clk(clk), .rst(rst), .dmem_s(ifc3));

  logic        resp_m;
  logic [31:0] rdata_m;
  assign resp_m  = sel ? ifc3.dmem_resp  : ifc2.dmem_resp;
  assign rdata_m = sel ? ifc3.dmem_rdata : ifc2.dmem_rdata;
`ifdef DMEM_RESP_ERR_EN
  logic err_m;
  assign err_m = sel ? ifc3.dmem_err : ifc2.dmem_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] model [int];
  logic [31:0] q_rdata [$];
  logic        q_err [$];

  function automatic logic [31:0] bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  function automatic bit legal(input logic [3:0] m);
    return (m == 4'b0001) || (m == 4'b0010) || (m == 4'b0100) || (m == 4'b1000) ||
           (m == 4'b0011) || (m == 4'b1100) || (m == 4'b1111);
  endfunction

  function automatic int mkey(input logic [31:0] a);
    return (sel ? 4096 : 0) + int'(a[11:2]);
  endfunction

  // Issue one request on the selected DUT; called just after a rising edge.
  task automatic do_req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] wd, output int resp_cyc);
    logic [31:0] exp_rd;
    logic        exp_er;
    logic [31:0] got_rd;
    logic        got_er;
    int          k;
    int          lat;
    lat = sel ? 3 : 2;
`ifdef DMEM_RESP_ERR_EN
    exp_er = (a >= 32'd4096) || (rm != 4'b0 && !legal(rm)) || (wm != 4'b0 && !legal(wm));
`else
    exp_er = 1'b0;
`endif
    exp_rd = (exp_er || rm == 4'b0) ? 32'b0 : (model[mkey(a)] & bits(rm));
    q_rdata.push_back(exp_rd);
    q_err.push_back(exp_er);
    addr_d = a; rm_d = rm; wm_d = wm; wdata_d = wd;
    k = 0;
    @(negedge clk);
    while (!resp_m && k < 20) begin
      n_vec++;
      if (rdata_m !== 32'b0) begin
        $display("FAIL rdata_idle: got %h want 00000000 (addr %h)", rdata_m, a);
        n_err++;
      end
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    resp_cyc = cyc;
    got_rd = rdata_m;
`ifdef DMEM_RESP_ERR_EN
    got_er = err_m;
`else
    got_er = 1'b0;
`endif
    exp_rd = q_rdata.pop_front();
    exp_er = q_err.pop_front();
    n_vec++;
    if (!resp_m) begin
      $display("FAIL resp_timeout: no dmem_resp within 20 cycles, want one after %0d (addr %h)", lat, a);
      n_err++;
    end else begin
      if (k != lat) begin
        $display("FAIL latency: got %0d cycles want %0d (addr %h)", k, lat, a);
        n_err++;
      end
      n_vec++;
      if (got_rd !== exp_rd) begin
        $display("FAIL rdata: got %h want %h (addr %h rmask %b)", got_rd, exp_rd, a, rm);
        n_err++;
      end
      n_vec++;
      if (got_er !== exp_er) begin
        $display("FAIL err: got %b want %b (addr %h)", got_er, exp_er, a);
        n_err++;
      end
    end
    if (wm != 4'b0 && !exp_er)
      model[mkey(a)] = (model.exists(mkey(a)) ? model[mkey(a)] : 32'b0) & ~bits(wm) | (wd & bits(wm));
    @(posedge clk);
    #1;
    rm_d = 4'b0; wm_d = 4'b0;
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_vec++;
      if (resp_m !== 1'b0 || rdata_m !== 32'b0) begin
        $display("FAIL %s: resp %b rdata %h want 0/00000000", tag, resp_m, rdata_m);
        n_err++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (ifc2.dmem_resp !== 1'b0 || ifc2.dmem_rdata !== 32'b0 ||
        ifc3.dmem_resp !== 1'b0 || ifc3.dmem_rdata !== 32'b0) begin
      $display("FAIL reset_outputs: resp %b/%b rdata %h/%h want 0", ifc2.dmem_resp,
               ifc3.dmem_resp, ifc2.dmem_rdata, ifc3.dmem_rdata);
      n_err++;
    end
`ifdef DMEM_RESP_ERR_EN
    n_vec++;
    if (ifc2.dmem_err !== 1'b0 || ifc3.dmem_err !== 1'b0) begin
      $display("FAIL reset_err: got %b/%b want 0", ifc2.dmem_err, ifc3.dmem_err);
      n_err++;
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_word_and_bytes();
    int c;
    sel = 1'b0;
    do_req(32'h10, 4'b0000, 4'b1111, 32'hDEADBEEF, c);
    do_req(32'h10, 4'b1111, 4'b0000, 32'h0, c);
    do_req(32'h13, 4'b0000, 4'b1000, 32'h55000000, c);
    do_req(32'h10, 4'b1111, 4'b0000, 32'h0, c);
    do_req(32'h12, 4'b1100, 4'b0000, 32'h0, c);
    do_req(32'h11, 4'b0010, 4'b0000, 32'h0, c);
  endtask

  task automatic test_abort();
    int c;
    sel = 1'b1;
    do_req(32'h20, 4'b0000, 4'b1111, 32'h11111111, c);
    addr_d = 32'h20; wm_d = 4'b1111; wdata_d = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    wm_d = 4'b0;
    idle_check(8, "abort_wait");
    addr_d = 32'h20; wm_d = 4'b1111; wdata_d = 32'hEEEEEEEE;
    repeat (3) @(posedge clk);
    #1;
    wm_d = 4'b0;
    idle_check(4, "abort_resp");
    do_req(32'h20, 4'b1111, 4'b0001, 32'h0, c);
    do_req(32'h20, 4'b1111, 4'b0000, 32'h0, c);
  endtask

  task automatic test_read_write_same();
    int c;
    sel = 1'b0;
    do_req(32'h30, 4'b0000, 4'b1111, 32'h2, c);
    do_req(32'h30, 4'b1111, 4'b1111, 32'h1, c);
    do_req(32'h30, 4'b1111, 4'b0000, 32'h0, c);
  endtask

  task automatic test_midflight_change();
    int c;
    sel = 1'b0;
    addr_d = 32'h40; wm_d = 4'b1111; wdata_d = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    addr_d = 32'h44; wm_d = 4'b0001; wdata_d = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (resp_m !== 1'b1) begin
      $display("FAIL midflight_resp: got %b want 1", resp_m);
      n_err++;
    end
    model[mkey(32'h40)] = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    wm_d = 4'b0;
    do_req(32'h40, 4'b1111, 4'b0000, 32'h0, c);
  endtask

  task automatic test_back_to_back();
    int c0, c1, c2;
    sel = 1'b0;
    do_req(32'h100, 4'b0000, 4'b1111, 32'h01020304, c0);
    do_req(32'h104, 4'b0000, 4'b0011, 32'h0000BEEF, c1);
    do_req(32'h100, 4'b0001, 4'b0000, 32'h0, c2);
    n_vec++;
    if (c1 - c0 != 3 || c2 - c1 != 3) begin
      $display("FAIL back_to_back: spacing %0d,%0d want 3,3", c1 - c0, c2 - c1);
      n_err++;
    end
  endtask

  task automatic test_reset_mid();
    int c;
    sel = 1'b0;
    do_req(32'h50, 4'b0000, 4'b1111, 32'h0BADF00D, c);
    addr_d = 32'h50; wm_d = 4'b1111; wdata_d = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wm_d = 4'b0;
    idle_check(3, "reset_mid");
    do_req(32'h50, 4'b1111, 4'b0000, 32'h0, c);
  endtask

  task automatic test_alias_err();
    int c;
    sel = 1'b0;
    do_req(32'h0, 4'b0000, 4'b1111, 32'hCAFEF00D, c);
    do_req(32'h1000, 4'b1111, 4'b0000, 32'h0, c);
`ifdef DMEM_RESP_ERR_EN
    do_req(32'h10, 4'b0101, 4'b0000, 32'h0, c);
    do_req(32'h10, 4'b0000, 4'b0110, 32'hFFFFFFFF, c);
    do_req(32'h10, 4'b1111, 4'b0000, 32'h0, c);
`endif
  endtask

  initial begin
    test_reset();
    test_word_and_bytes();
    test_abort();
    test_read_write_same();
    test_midflight_change();
    test_back_to_back();
    test_reset_mid();
    test_alias_err();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
